// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI4 read channel between Icache and Dcache; AXI_RD_ARB_RR_EN selects round-robin
module axi_rd_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int ICACHE_ID = 0,
  parameter int DCACHE_ID = 1
) (
  input  logic              clk,
  input  logic              rst,
  // Icache requester
  input  logic              i_arvalid,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  output logic              i_arready,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  input  logic              i_rready,
  // Dcache requester
  input  logic              d_arvalid,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  output logic              d_arready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  input  logic              d_rready,
  // AXI master read channel
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [ID_W-1:0]   arid,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid,
  output logic              rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t state;
  logic   grant_d;
  logic   req_any;
  logic   pick_d;
  logic   in_rd;
  logic   beat_done;
  logic   unused_rid;

`ifdef AXI_RD_ARB_RR_EN
  logic   last_grant_d;
`endif

  // Only one burst is ever outstanding, so the returned ID carries no information.
  assign unused_rid = ^rid;

  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Pick the winner while idle; reset masks the accept pulses so every output is quiet during reset
  always_comb begin
    req_any = 1'b0;
    pick_d  = 1'b0;
    if (state == S_IDLE && !rst) begin
      req_any = i_arvalid | d_arvalid;
`ifdef AXI_RD_ARB_RR_EN
      if (i_arvalid && d_arvalid) begin
        pick_d = ~last_grant_d;
      end else begin
        pick_d = d_arvalid;
      end
`else
      pick_d = d_arvalid;
`endif
    end
  end

  assign d_arready = req_any & pick_d;
  assign i_arready = req_any & ~pick_d;

  // R beats go only to the owner of the burst, and only while the data phase is active
  assign in_rd     = (state == S_RD);
  assign rready    = in_rd & (grant_d ? d_rready : i_rready);
  assign i_rvalid  = in_rd & ~grant_d & rvalid;
  assign i_rlast   = in_rd & ~grant_d & rlast;
  assign d_rvalid  = in_rd & grant_d & rvalid;
  assign d_rlast   = in_rd & grant_d & rlast;
  assign i_rdata   = in_rd ? rdata : '0;
  assign d_rdata   = in_rd ? rdata : '0;
  assign beat_done = rvalid & rready & rlast;

  // Channel FSM: latch the winner's request, present it on AR, then stay until the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      grant_d <= 1'b0;
      arvalid <= 1'b0;
      araddr  <= '0;
      arlen   <= '0;
      arid    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            grant_d <= pick_d;
            arvalid <= 1'b1;
            araddr  <= pick_d ? d_araddr : i_araddr;
            arlen   <= pick_d ? d_arlen : i_arlen;
            arid    <= pick_d ? ID_W'(DCACHE_ID) : ID_W'(ICACHE_ID);
            state   <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= S_RD;
          end
        end
        S_RD: begin
          if (beat_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          arvalid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef AXI_RD_ARB_RR_EN
  // Remember the most recent winner so that contending requesters alternate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_d <= 1'b0;
    end else if (req_any) begin
      last_grant_d <= pick_d;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - randomized scoreboard bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  localparam int NCYC  = 3000;
  localparam int QUIET = 2600;

  logic        clk;
  logic        rst;
  logic        i_arvalid, d_arvalid;
  logic [31:0] i_araddr, d_araddr;
  logic [7:0]  i_arlen, d_arlen;
  logic        i_rready, d_rready;
  logic        i_arready, d_arready;
  logic        i_rvalid, d_rvalid, i_rlast, d_rlast;
  logic [31:0] i_rdata, d_rdata;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [3:0]  arid, rid;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rready(d_rready),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arid(arid), .arsize(arsize),
    .arburst(arburst), .arready(arready), .rvalid(rvalid), .rdata(rdata), .rlast(rlast),
    .rid(rid), .rready(rready)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int    n_cmp;
  int    n_bad;
  bit    run;
  logic [7:0] cq[$];
  ar_t   arq[$];
  beat_t iq[$];
  beat_t dq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic underflow(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced an output with nothing expected at %0t", name, $time);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ctrl"}, 64'({arvalid, rready, i_rvalid, i_rlast, d_rvalid, d_rlast, i_arready, d_arready}), 64'(0));
    chk({tag, "_ar_regs"}, 64'({arid, araddr, arlen}), 64'(0));
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'(0));
    chk({tag, "_consts"}, 64'({arsize, arburst}), 64'({3'b010, 2'b01}));
  endtask

  // Monitor: every cycle compare control outputs; on each handshake pop the matching expected item
  initial begin
    logic [7:0] v;
    ar_t        a;
    beat_t      b;
    forever begin
      @(negedge clk);
      if (!run || rst) continue;
      v = {arvalid, rready, i_rvalid, i_rlast, d_rvalid, d_rlast, i_arready, d_arready};
      if (cq.size() == 0) underflow("ctrl_queue");
      else chk("ctrl", 64'(v), 64'(cq.pop_front()));
      if (arvalid && arready) begin
        if (arq.size() == 0) underflow("ar_queue");
        else begin
          a = arq.pop_front();
          chk("ar_req", 64'({arid, araddr, arlen}), 64'(a));
          chk("ar_consts", 64'({arsize, arburst}), 64'({3'b010, 2'b01}));
        end
      end
      if (i_rvalid && i_rready) begin
        if (iq.size() == 0) underflow("i_beat_queue");
        else begin
          b = iq.pop_front();
          chk("i_beat", 64'({i_rdata, i_rlast}), 64'(b));
        end
      end
      if (d_rvalid && d_rready) begin
        if (dq.size() == 0) underflow("d_beat_queue");
        else begin
          b = dq.pop_front();
          chk("d_beat", 64'({d_rdata, d_rlast}), 64'(b));
        end
      end
    end
  end

  // Stimulus plus reference model: the channel is free, waiting on AR, or returning data for one owner
  initial begin
    int    phase;
    int    beat;
    int    rst_left;
    bit    owner, last_d, i_gnt, d_gnt, gi, gd, w, own_rdy, rst_done;
    ar_t   cur;
    beat_t bt;
    logic [7:0] exp_v;

    n_cmp = 0; n_bad = 0; run = 1'b0;
    phase = 0; beat = 0; rst_left = 0;
    owner = 1'b0; last_d = 1'b0; i_gnt = 1'b0; d_gnt = 1'b0; rst_done = 1'b0;
    cur = '0;
    rst = 1'b1;
    i_arvalid = 1'b0; i_araddr = '0; i_arlen = '0; i_rready = 1'b0;
    d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_rready = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    run = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;

      if (rst_left > 0) begin
        rst_left--;
        continue;
      end
      if (!rst_done && cyc > 1500 && phase == 2 && beat == 1 && cur.len >= 8'd2) begin
        rst = 1'b1;
        rst_done = 1'b1;
        rst_left = 1;
        phase = 0; beat = 0; last_d = 1'b0; i_gnt = 1'b0; d_gnt = 1'b0;
        cq.delete(); arq.delete(); iq.delete(); dq.delete();
        rvalid = 1'b1; arready = 1'b1; i_rready = 1'b1; d_rready = 1'b1;
        #1;
        check_quiet("mid_burst_reset");
        continue;
      end
      rst = 1'b0;

      // Icache requester: the first request is the fixed refill from the plan
      if (cyc == 0) begin
        i_arvalid = 1'b1; i_araddr = 32'h1c00_0040; i_arlen = 8'd3;
      end else if (i_gnt) begin
        i_arvalid = 1'b0; i_gnt = 1'b0;
      end else if (i_arvalid && cyc > 20 && $urandom_range(15) == 0) begin
        i_arvalid = 1'b0;
      end else if (!i_arvalid && cyc < QUIET && $urandom_range(3) == 0) begin
        i_arvalid = 1'b1; i_araddr = $urandom() & ~32'h3; i_arlen = 8'($urandom_range(4));
      end

      // Dcache requester: silent at first so the Icache refill runs alone
      if (d_gnt) begin
        d_arvalid = 1'b0; d_gnt = 1'b0;
      end else if (d_arvalid && $urandom_range(15) == 0) begin
        d_arvalid = 1'b0;
      end else if (!d_arvalid && cyc > 20 && cyc < QUIET && $urandom_range(3) == 0) begin
        d_arvalid = 1'b1; d_araddr = $urandom() & ~32'h3;
        d_arlen = ($urandom_range(2) == 0) ? 8'd0 : 8'($urandom_range(4));
      end

      i_rready = ($urandom_range(3) != 0);
      d_rready = ($urandom_range(3) != 0);

      // AXI slave; stray rvalid outside the data phase must be ignored
      arready = 1'b0;
      rdata   = $urandom();
      rid     = 4'($urandom());
      if (phase == 2) begin
        rvalid = ($urandom_range(3) != 0);
        rlast  = (beat == int'(cur.len));
      end else begin
        rvalid = ($urandom_range(7) == 0);
        rlast  = 1'($urandom_range(1));
        if (phase == 1) arready = ($urandom_range(2) == 0);
      end

      // Expected behaviour this cycle
      gi = 1'b0; gd = 1'b0;
      if (phase == 0 && (i_arvalid || d_arvalid)) begin
`ifdef AXI_RD_ARB_RR_EN
        w = (i_arvalid && d_arvalid) ? !last_d : d_arvalid;
`else
        w = d_arvalid;
`endif
        gd = w; gi = !w;
      end
      own_rdy = owner ? d_rready : i_rready;
      exp_v = {phase == 1,
               phase == 2 && own_rdy,
               phase == 2 && !owner && rvalid,
               phase == 2 && !owner && rlast,
               phase == 2 && owner && rvalid,
               phase == 2 && owner && rlast,
               gi, gd};
      cq.push_back(exp_v);

      // Advance the model for the next cycle
      if (gi || gd) begin
        owner = gd; last_d = gd;
        cur = gd ? '{id: 4'd1, addr: d_araddr, len: d_arlen}
                 : '{id: 4'd0, addr: i_araddr, len: i_arlen};
        arq.push_back(cur);
        beat = 0; phase = 1;
        i_gnt = gi; d_gnt = gd;
      end else if (phase == 1) begin
        if (arready) phase = 2;
      end else if (phase == 2 && rvalid && own_rdy) begin
        bt = '{data: rdata, last: rlast};
        if (owner) dq.push_back(bt);
        else iq.push_back(bt);
        if (rlast) phase = 0;
        else beat++;
      end
    end

    @(negedge clk);
    #1;
    run = 1'b0;
    chk("ctrl_queue_drained", 64'(cq.size()), 64'(0));
    chk("ar_queue_drained", 64'(arq.size()), 64'(0));
    chk("i_beats_drained", 64'(iq.size()), 64'(0));
    chk("d_beats_drained", 64'(dq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI4 read channel (AR/R) between the Icache refill/uncached port and the Dcache refill/uncached port.
- Allows one outstanding burst at a time.
- Registers the winning request, drives AR, then steers the R beats back to the winner until the beat carrying rlast.
- Sits between both cache FSMs and the top-level AXI bridge.

Parameters:
- ADDR_W, 32, address width of both requesters and the AXI master.
- DATA_W, 32, read data width.
- ID_W, 4, arid width.
- ICACHE_ID, 0, arid driven for Icache bursts.
- DCACHE_ID, 1, arid driven for Dcache bursts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_arvalid  in  1  Icache read request; held until i_arready.
- i_araddr  in  ADDR_W  Icache burst start address.
- i_arlen  in  8  Icache burst length minus 1.
- i_arready  out  1  Icache request accepted (one-cycle pulse).
- i_rvalid  out  1  beat valid to Icache.
- i_rdata  out  DATA_W  beat data to Icache.
- i_rlast  out  1  last beat to Icache.
- i_rready  in  1  Icache can accept a beat.
- d_arvalid, d_araddr, d_arlen, d_arready, d_rvalid, d_rdata, d_rlast, d_rready: same as the i_* ports, for the Dcache.
- arvalid  out  1  AXI AR valid.
- araddr  out  ADDR_W  AXI AR address.
- arlen  out  8  AXI AR length.
- arid  out  ID_W  AXI AR ID.
- arsize  out  3  constant 3'b010.
- arburst  out  2  constant 2'b01 (INCR).
- arready  in  1  AXI AR ready.
- rvalid  in  1  AXI R valid.
- rdata  in  DATA_W  AXI R data.
- rlast  in  1  AXI R last.
- rid  in  ID_W  AXI R ID; unused, only one burst is ever outstanding.
- rready  out  1  AXI R ready.

Behaviour:
- FSM states: IDLE, AR, RD. Register grant_d (0 = Icache owns the channel, 1 = Dcache).
- IDLE:
  - If d_arvalid: grant_d <= 1, d_arready = 1 combinationally this cycle.
  - Else if i_arvalid: grant_d <= 0, i_arready = 1.
  - On either grant, capture the winner's araddr/arlen and arid (DCACHE_ID or ICACHE_ID) into output registers, then go to AR.
  - No request: stay in IDLE.
- AR: arvalid = 1 with the registered araddr/arlen/arid. When arready is high, go to RD. Both *_arready outputs are 0.
- RD:
  - rready = grant_d ? d_rready : i_rready.
  - Winner's *_rvalid = rvalid; loser's *_rvalid = 0.
  - i_rdata and d_rdata both = rdata. *_rlast = rlast gated the same way as *_rvalid.
  - On rvalid & rready & rlast: go to IDLE.
- Latency:
  - Request to arvalid: 1 cycle.
  - A new request is accepted no earlier than the cycle after the last beat; there is no back-to-back overlap.
- Outside AR: arvalid = 0. Outside RD: rready = 0 and all *_rvalid/*_rlast = 0.
- Simultaneous i_arvalid and d_arvalid in IDLE: Dcache wins (fixed priority). The Icache request stays pending and is served on the next IDLE visit.
- A requester that drops *_arvalid before being granted is simply not served.
- A single-beat burst (arlen = 0) is legal: RD exits on its first handshaked beat.
- rvalid while in IDLE or AR is a protocol error: ignored, rready stays 0.
- Reset, including mid-burst:
  - State <= IDLE, grant_d <= 0.
  - araddr/arlen/arid registers <= 0.
  - All outputs 0 except arsize/arburst, which stay at their constants.
  - Remaining beats of the aborted burst are not consumed.

Optional Feature:
- Macro: AXI_RD_ARB_RR_EN.
- Defined: round-robin on simultaneous requests. A last_grant_d register (reset 0) updates on every grant. When both request in IDLE, the requester that did not win the previous grant wins. Single requests are served directly.
- Undefined: fixed Dcache priority as described above, and no last_grant_d register.

Test Plan:
- Icache only:
  - Stimulus: i_arvalid = 1, i_araddr = 0x1c000040, i_arlen = 3; arready after 2 cycles; 4 beats 0xA0..0xA3.
  - Required: i_arready pulses once; arid = 0, araddr = 0x1c000040, arlen = 3; i_rvalid on 4 beats with i_rlast only on 0xA3; d_rvalid stays 0; FSM returns to IDLE.
- Simultaneous requests, fixed priority:
  - Stimulus: i_arvalid and d_arvalid (d_araddr = 0x00001000, d_arlen = 0) both asserted.
  - Required: Dcache burst first with arid = 1, then the Icache burst starts the cycle after the Dcache rlast beat.
- Back-pressure:
  - Stimulus: during an Icache 4-beat burst, i_rready = 0 for beats 2-3.
  - Required: rready = 0 on those cycles, no beat lost, total of 4 handshaked beats.
- Uncached single beat:
  - Stimulus: d_arlen = 0, one beat with rlast = 1.
  - Required: RD exits after 1 beat; a new i_arvalid is accepted the next cycle.
- Reset mid-burst:
  - Stimulus: assert rst after beat 1 of 4.
  - Required: outputs go 0 immediately (asynchronous); after rst deasserts, FSM is in IDLE and a fresh request is accepted.
- With AXI_RD_ARB_RR_EN defined:
  - Stimulus: both requesters assert continuously for 4 bursts.
  - Required: grant order D, I, D, I.
